// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file write path.
//   - state_e       : write-port controller states (ARB, CLEAR)
//   - DEF_*         : default geometry of the 16x32 register file
//   - DEF_PROT_ADDR : register guarded when REGFILE_WR_PROTECT_EN is defined
//   - rr_next       : round-robin successor of an index
package regfile_ctrl_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_REGS  = 16;
  localparam int DEF_PROT_ADDR = 15;

  // Index following idx in a ring of n entries.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant selection.
// Ports:
//   valid_i     [NUM_REQ]  request bits
//   ptr_i       [PTR_W]    highest-priority index this cycle (held by parent)
//   grant_o     [NUM_REQ]  one-hot grant (all zero when nothing is valid)
//   grant_idx_o [PTR_W]    index of the granted requester
//   grant_any_o            at least one request is valid
module rr_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   grant_idx_o,
  output logic               grant_any_o
);

  int cand;

  // Walk ptr, ptr+1, ... around the ring; the first valid index wins.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    grant_any_o = 1'b0;
    cand        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr_i) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_any_o && valid_i[cand]) begin
        grant_any_o   = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: owns the single write port of the register file.
// Round-robin shares the port between NUM_REQ writeback sources and runs a
// "clear all" sweep that writes zero to registers 0..NUM_REGS-1.
// Outputs are registered on posedge; the register file commits on the
// following negedge.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/addr/data      packed requester inputs, slice i = requester i
//   req_ready                combinational one-hot grant
//   clear_start              one-cycle sweep request (ignored while sweeping)
//   clear_busy, clear_done   sweep in progress / one-cycle completion pulse
//   reg_write, dir_WR, data_in  register-file write port
//   prot_err                 (REGFILE_WR_PROTECT_EN only) blocked write pulse
//   state_dbg                current controller state, for observation
// Optional feature macro: REGFILE_WR_PROTECT_EN -- requesters other than 0
// may not write PROT_ADDR; their handshake completes but no write is issued.
//
// Handshake: a transfer happens on a posedge where req_valid[i] & req_ready[i].
// A requester holds valid/addr/data stable until it sees ready; it may drop
// valid without a transfer. ready never depends on anything registered later
// than the current cycle and is at most one-hot.
module regfile_write_arbiter
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS
`ifdef REGFILE_WR_PROTECT_EN
  ,
  parameter int PROT_ADDR = DEF_PROT_ADDR
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic                        reg_write,
  output logic [ADDR_W-1:0]           dir_WR,
  output logic [DATA_W-1:0]           data_in,
`ifdef REGFILE_WR_PROTECT_EN
  output logic                        prot_err,
`endif
  output state_e                      state_dbg
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so the terminal count NUM_REGS is representable.
  localparam int CNT_W = ADDR_W + 1;

  state_e             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               reg_write_q;
  logic [ADDR_W-1:0]  dir_wr_q;
  logic [DATA_W-1:0]  data_in_q;
  logic               clear_done_q;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               accept;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .valid_i     (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // The cycle carrying clear_done is also held off so the first requester
  // grant after a sweep lands in the cycle after the done pulse.
  assign accept    = grant_any && (state_q == ARB) && !clear_start && !clear_done_q;
  assign req_ready = accept ? grant : '0;

  assign g_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign g_data = req_data[int'(grant_idx)*DATA_W +: DATA_W];

`ifdef REGFILE_WR_PROTECT_EN
  logic prot_err_q;
  logic prot_hit;
  assign prot_hit = (grant_idx != '0) && (g_addr == ADDR_W'(PROT_ADDR));
  assign prot_err = prot_err_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      ptr_q        <= '0;
      cnt_q        <= '0;
      reg_write_q  <= 1'b0;
      dir_wr_q     <= '0;
      data_in_q    <= '0;
      clear_done_q <= 1'b0;
`ifdef REGFILE_WR_PROTECT_EN
      prot_err_q   <= 1'b0;
`endif
    end else begin
      clear_done_q <= 1'b0;
`ifdef REGFILE_WR_PROTECT_EN
      prot_err_q   <= 1'b0;
`endif
      case (state_q)
        ARB: begin
          if (clear_start) begin
            // Address 0 is written on the starting edge itself.
            state_q     <= CLEAR;
            reg_write_q <= 1'b1;
            dir_wr_q    <= '0;
            data_in_q   <= '0;
            cnt_q       <= CNT_W'(1);
          end else if (accept) begin
            ptr_q <= PTR_W'(rr_next(int'(grant_idx), NUM_REQ));
`ifdef REGFILE_WR_PROTECT_EN
            if (prot_hit) begin
              reg_write_q <= 1'b0;
              prot_err_q  <= 1'b1;
            end else begin
              reg_write_q <= 1'b1;
              dir_wr_q    <= g_addr;
              data_in_q   <= g_data;
            end
`else
            reg_write_q <= 1'b1;
            dir_wr_q    <= g_addr;
            data_in_q   <= g_data;
`endif
          end else begin
            reg_write_q <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt_q < CNT_W'(NUM_REGS)) begin
            reg_write_q <= 1'b1;
            dir_wr_q    <= cnt_q[ADDR_W-1:0];
            data_in_q   <= '0;
            cnt_q       <= cnt_q + CNT_W'(1);
          end else begin
            reg_write_q  <= 1'b0;
            state_q      <= ARB;
            clear_done_q <= 1'b1;
            cnt_q        <= '0;
          end
        end
        default: begin
          state_q     <= ARB;
          reg_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign reg_write  = reg_write_q;
  assign dir_WR     = dir_wr_q;
  assign data_in    = data_in_q;
  assign clear_busy = (state_q == CLEAR);
  assign clear_done = clear_done_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  import regfile_ctrl_pkg::*;

  localparam int NUM_REQ  = 3;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int EW       = ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr  = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      clear_start = 1'b0;
  logic                      clear_busy, clear_done, reg_write;
  logic [ADDR_W-1:0]         dir_WR;
  logic [DATA_W-1:0]         data_in;
  state_e                    state_dbg;
`ifdef REGFILE_WR_PROTECT_EN
  logic                      prot_err;
`endif

  regfile_write_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .reg_write   (reg_write),
    .dir_WR      (dir_WR),
    .data_in     (data_in),
`ifdef REGFILE_WR_PROTECT_EN
    .prot_err    (prot_err),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] rf [NUM_REGS] = '{default: 32'hA5A5_A5A5};
  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int done_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: models the register file commit on negedge and checks each write
  // against the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (!rst) begin
      if (clear_busy) busy_cycles++;
      if (clear_done) done_pulses++;
      if (reg_write) begin
        rf[dir_WR] = data_in;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", dir_WR, data_in);
        end else begin
          check("write", {28'd0, dir_WR, data_in}, {28'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[i] = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic push_clear();
    for (int i = 0; i < NUM_REGS; i++) exp_q.push_back({ADDR_W'(i), 32'h0});
  endtask

  task automatic wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (clear_done) break;
      step();
    end
    check("clear_done_seen", clear_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic all_zero;
    repeat (2) @(posedge clk);
    #1;
    check("rst_reg_write", reg_write, 0);
    check("rst_dir_WR", dir_WR, 0);
    check("rst_data_in", data_in, 0);
    check("rst_busy", clear_busy, 0);
    check("rst_done", clear_done, 0);
    check("rst_state", state_dbg, ARB);
    rst = 1'b0;
    step();

    // 1: single write
    set_req(0, 1'b1, 4'd5, 32'hDEAD_BEEF);
    exp_q.push_back({4'd5, 32'hDEAD_BEEF});
    #1 check("t1_ready", req_ready, 3'b001);
    step();
    set_req(0, 1'b0, 4'd0, 32'h0);
    check("t1_reg_write", reg_write, 1);
    check("t1_dir_WR", dir_WR, 5);
    check("t1_data_in", data_in, 32'hDEAD_BEEF);
    step();
    check("t1_rf5", rf[5], 32'hDEAD_BEEF);

    // 2: round robin from ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 1'b1, 4'd1, 32'h1111_1111);
    set_req(1, 1'b1, 4'd2, 32'h2222_2222);
    set_req(2, 1'b1, 4'd3, 32'h3333_3333);
    #1;
    for (int k = 0; k < 6; k++) begin
      check("t2_ready", req_ready, 3'b001 << (k % 3));
      exp_q.push_back({ADDR_W'(k % 3 + 1), {8{4'(k % 3 + 1)}}});
      step();
    end
    req_valid = '0;
    step();

    // 3: clear versus request on the same edge
    clear_start = 1'b1;
    set_req(0, 1'b1, 4'd6, 32'h0000_1234);
    #1 check("t3_ready_at_start", req_ready, 3'b000);
    push_clear();
    step();
    clear_start = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      check("t3_busy", clear_busy, 1);
      check("t3_ready_busy", req_ready, 3'b000);
      check("t3_dir_step", dir_WR, i);
      step();
    end
    check("t3_busy_end", clear_busy, 0);
    check("t3_done", clear_done, 1);
    check("t3_ready_done_cycle", req_ready, 3'b000);
    all_zero = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) if (rf[i] !== 32'h0) all_zero = 1'b0;
    check("t3_all_zero", all_zero, 1);
    check("t3_busy_cycles", busy_cycles, NUM_REGS);
    exp_q.push_back({4'd6, 32'h0000_1234});
    step();
    check("t3_done_clear", clear_done, 0);
    check("t3_ready_after", req_ready, 3'b001);
    step();
    set_req(0, 1'b0, 4'd0, 32'h0);
    check("t3_write_after", dir_WR, 6);
    check("t3_done_pulses", done_pulses, 1);
    step();

    // 4: reset mid-clear
    clear_start = 1'b1;
    for (int i = 0; i < 7; i++) exp_q.push_back({ADDR_W'(i), 32'h0});
    step();
    clear_start = 1'b0;
    repeat (7) step();
    check("t4_dir7", dir_WR, 7);
    #1 rst = 1'b1;
    #1;
    check("t4_rst_reg_write", reg_write, 0);
    check("t4_rst_dir", dir_WR, 0);
    check("t4_rst_busy", clear_busy, 0);
    step();
    rst = 1'b0;
    check("t4_state_arb", state_dbg, ARB);
    check("t4_sb_drained", exp_q.size(), 0);
    clear_start = 1'b1;
    push_clear();
    step();
    clear_start = 1'b0;
    check("t4_restart_addr", dir_WR, 0);
    check("t4_restart_we", reg_write, 1);
    wait_done(40);
    step();

    // 5: clear_start re-pulsed at cnt=4
    done_pulses = 0;
    busy_cycles = 0;
    clear_start = 1'b1;
    push_clear();
    step();
    clear_start = 1'b0;
    repeat (3) step();
    check("t5_dir3", dir_WR, 3);
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    check("t5_dir4", dir_WR, 4);
    check("t5_busy", clear_busy, 1);
    wait_done(40);
    repeat (3) step();
    check("t5_done_pulses", done_pulses, 1);
    check("t5_busy_cycles", busy_cycles, NUM_REGS);
    check("t5_sb_drained", exp_q.size(), 0);

`ifdef REGFILE_WR_PROTECT_EN
    // 6: protected address
    set_req(1, 1'b1, 4'd15, 32'hBAD0_BAD0);
    #1 check("t6_ready_r1", req_ready, 3'b010);
    step();
    set_req(1, 1'b0, 4'd0, 32'h0);
    check("t6_prot_err", prot_err, 1);
    check("t6_no_write", reg_write, 0);
    step();
    check("t6_prot_err_clear", prot_err, 0);
    check("t6_rf15_kept", rf[15], 32'h0);
    set_req(0, 1'b1, 4'd15, 32'hCAFE_F00D);
    exp_q.push_back({4'd15, 32'hCAFE_F00D});
    #1 check("t6_ready_r0", req_ready, 3'b001);
    step();
    set_req(0, 1'b0, 4'd0, 32'h0);
    check("t6_r0_write", reg_write, 1);
    step();
    check("t6_rf15_written", rf[15], 32'hCAFE_F00D);
`endif

    repeat (2) step();
    check("final_sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
